mode_counter: RTL and testbench
===============================

MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port mode, input, 2, selecting the step: 00 up 1, 01 up 2, 10 down 1, 11 down 2.
REQ-005 The block SHALL have port init, input, 1, a load strobe for init_value.
REQ-006 The block SHALL have port init_value, input, WIDTH, the value loaded on init.
REQ-007 The block SHALL have port gameover, input, 1, a freeze request driven by the downstream winner/loser tally stage.
REQ-008 The block SHALL have port count, output, WIDTH, the current counter value.
REQ-009 The block SHALL have port winner_flag, output, 1, a one-cycle pulse when a step lands on all-ones.
REQ-010 The block SHALL have port loser_flag, output, 1, a one-cycle pulse when a step lands on zero.

Function
REQ-011 Each rising edge, the block SHALL apply these priorities in order: reset, then gameover freeze, then load, then step.
REQ-012 While gameover=1, the block SHALL hold count, force both flags to 0 and ignore init.
REQ-013 When init=1 and gameover=0, the block SHALL load count with init_value, drive both flags 0 and take no step that cycle.
REQ-014 Otherwise, the block SHALL add or subtract the mode-selected step to count, modulo 2^WIDTH (e.g. 14+2=0, 1-2=15 for WIDTH=4).
REQ-015 The mode input SHALL be sampled every cycle with no latency, so a change takes effect on the next step.
REQ-016 winner_flag SHALL be registered and asserted in the same cycle count first shows all-ones as the result of a step.
REQ-017 loser_flag SHALL be registered and asserted in the same cycle count first shows zero as the result of a step, including a wrap.
REQ-018 Each flag SHALL be a single-cycle pulse per qualifying step, deasserted on any cycle without one.
REQ-019 winner_flag and loser_flag SHALL never be asserted together.
REQ-020 A load of zero or all-ones SHALL NOT assert either flag.
REQ-021 A step that skips over a limit value without landing on it (e.g. up 2 from 14 to 0) SHALL flag only the landed value.

Reset
REQ-022 While rst_n=0 at a rising edge, the block SHALL set count to 0 and winner_flag and loser_flag to 0, overriding all other inputs.
REQ-023 The block SHALL NOT assert loser_flag for the zero produced by reset.
REQ-024 After rst_n rises, the block SHALL resume stepping from 0 on the first edge with rst_n=1.
REQ-025 Reset asserted mid-operation SHALL discard any flag that would have been produced on that edge.

Configuration
REQ-026 When macro HOLD_PORT_EN is defined, the block SHALL have an extra input port hold, 1 bit; hold=1 SHALL freeze count and force flags to 0, at priority below gameover and above load.
REQ-027 When HOLD_PORT_EN is undefined, the block SHALL have no hold port and SHALL behave as if hold=0.

Verification
REQ-028 Bench: reset, then mode=00 for 16 cycles -> count 1..15 with winner_flag only at 15, then count 0 with loser_flag only.
REQ-029 Bench: init=1 with init_value=10, then mode=01 -> count 10 with no flag, then 12, 14, then 0 with loser_flag.
REQ-030 Bench: load 3, then mode=11 -> count 1, then 15 with winner_flag, then 13 with no flag.
REQ-031 Bench: init=1 with init_value=5 in the same cycle as a mode=00 step -> count 5 with no flag.
REQ-032 Bench: gameover=1 at count=7 for 3 cycles with init=1 pulsed -> count stays 7 with flags 0; gameover=0 and mode=00 -> count 8.
REQ-033 Bench: rst_n=0 on the edge where count would step 14 to 15 -> count 0, winner_flag 0, loser_flag 0; with HOLD_PORT_EN, hold=1 freezes count.

Source files
------------

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - wrapping up/down step counter with winner/loser landing pulses; HOLD_PORT_EN adds a hold input
module mode_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             init,
  input  logic [WIDTH-1:0] init_value,
  input  logic             gameover,
`ifdef HOLD_PORT_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] count,
  output logic             winner_flag,
  output logic             loser_flag
);

  logic             hold_req;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] stepped;

`ifdef HOLD_PORT_EN
  assign hold_req = hold;
`else
  assign hold_req = 1'b0;
`endif

  // Step size and direction come straight from mode each cycle; the sum wraps naturally at WIDTH bits.
  always_comb begin
    step    = mode[0] ? WIDTH'(2) : WIDTH'(1);
    stepped = mode[1] ? (count - step) : (count + step);
  end

  // Reset, then freeze (gameover, then hold), then load, then step; flags only ever come from a step landing on a limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      winner_flag <= 1'b0;
      loser_flag  <= 1'b0;
    end else if (gameover || hold_req) begin
      winner_flag <= 1'b0;
      loser_flag  <= 1'b0;
    end else if (init) begin
      count       <= init_value;
      winner_flag <= 1'b0;
      loser_flag  <= 1'b0;
    end else begin
      count       <= stepped;
      winner_flag <= &stepped;
      loser_flag  <= (stepped == '0);
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - self-checking bench for mode_counter: arithmetic reference model plus directed literal checks
module tb_mode_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             init = 1'b0;
  logic [WIDTH-1:0] init_value = '0;
  logic             gameover = 1'b0;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] count;
  logic             winner_flag;
  logic             loser_flag;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int m_count = 0;
  bit m_win = 0;
  bit m_lose = 0;
  bit m_valid = 0;

  mode_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .init        (init),
    .init_value  (init_value),
    .gameover    (gameover),
`ifdef HOLD_PORT_EN
    .hold        (hold),
`endif
    .count       (count),
    .winner_flag (winner_flag),
    .loser_flag  (loser_flag)
  );

  always #5 clk = ~clk;

  // Reference model: signed arithmetic on an integer, folded back into 0..MOD-1.
  always @(posedge clk) begin
    int delta;
    if (!rst_n) begin
      m_count = 0; m_win = 0; m_lose = 0; m_valid = 1;
    end else if (gameover || hold) begin
      m_win = 0; m_lose = 0;
    end else if (init) begin
      m_count = int'(init_value); m_win = 0; m_lose = 0;
    end else begin
      delta   = (mode[0] ? 2 : 1) * (mode[1] ? -1 : 1);
      m_count = (m_count + delta + MOD) % MOD;
      m_win   = (m_count == MOD - 1);
      m_lose  = (m_count == 0);
    end
  end

  // Compare DUT against the model every cycle once the model is defined.
  always @(negedge clk) begin
    if (m_valid) begin
      compared++;
      if (count !== WIDTH'(m_count) || winner_flag !== m_win || loser_flag !== m_lose) begin
        mismatched++;
        $display("FAIL model t=%0t: got count=%0d win=%b lose=%b, expected count=%0d win=%b lose=%b",
                 $time, count, winner_flag, loser_flag, m_count, m_win, m_lose);
      end
    end
  end

  task automatic tick(input logic r, input logic [1:0] md, input logic in, input logic [3:0] iv,
                      input logic go, input logic hd);
    rst_n = r; mode = md; init = in; init_value = iv; gameover = go; hold = hd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int ec, input bit ew, input bit el);
    compared++;
    if (count !== WIDTH'(ec) || winner_flag !== ew || loser_flag !== el) begin
      mismatched++;
      $display("FAIL %s: got count=%0d win=%b lose=%b, expected count=%0d win=%b lose=%b",
               nm, count, winner_flag, loser_flag, ec, ew, el);
    end
  endtask

  initial begin
    // reset
    tick(0, 2'b00, 1, 4'd9, 0, 0); chk("reset", 0, 0, 0);

    // count up by 1 through a full wrap
    for (int i = 1; i <= 16; i++) begin
      tick(1, 2'b00, 0, 0, 0, 0);
      chk("up1_sweep", i % 16, (i == 15), (i == 16));
    end

    // load 10, up by 2 to a wrap landing on 0
    tick(1, 2'b01, 1, 4'd10, 0, 0); chk("load10", 10, 0, 0);
    tick(1, 2'b01, 0, 0, 0, 0);     chk("up2_12", 12, 0, 0);
    tick(1, 2'b01, 0, 0, 0, 0);     chk("up2_14", 14, 0, 0);
    tick(1, 2'b01, 0, 0, 0, 0);     chk("up2_wrap0", 0, 0, 1);

    // load 3, down by 2 across the wrap
    tick(1, 2'b11, 1, 4'd3, 0, 0);  chk("load3", 3, 0, 0);
    tick(1, 2'b11, 0, 0, 0, 0);     chk("dn2_1", 1, 0, 0);
    tick(1, 2'b11, 0, 0, 0, 0);     chk("dn2_15", 15, 1, 0);
    tick(1, 2'b11, 0, 0, 0, 0);     chk("dn2_13", 13, 0, 0);

    // load wins over a simultaneous step
    tick(1, 2'b00, 1, 4'd5, 0, 0);  chk("load_over_step", 5, 0, 0);

    // gameover freeze ignores init
    tick(1, 2'b00, 1, 4'd7, 0, 0);  chk("load7", 7, 0, 0);
    tick(1, 2'b00, 0, 4'd2, 1, 0);  chk("gameover_a", 7, 0, 0);
    tick(1, 2'b00, 1, 4'd2, 1, 0);  chk("gameover_init", 7, 0, 0);
    tick(1, 2'b00, 0, 4'd2, 1, 0);  chk("gameover_c", 7, 0, 0);
    tick(1, 2'b00, 0, 0, 0, 0);     chk("after_gameover", 8, 0, 0);

    // gameover clears a pending winner pulse
    tick(1, 2'b00, 1, 4'd14, 0, 0); chk("load14", 14, 0, 0);
    tick(1, 2'b00, 0, 0, 0, 0);     chk("win15", 15, 1, 0);
    tick(1, 2'b00, 0, 0, 1, 0);     chk("gameover_drop", 15, 0, 0);

    // down 1 through zero, loads of limit values
    tick(1, 2'b10, 1, 4'd1, 0, 0);  chk("load1", 1, 0, 0);
    tick(1, 2'b10, 0, 0, 0, 0);     chk("dn1_0", 0, 0, 1);
    tick(1, 2'b10, 0, 0, 0, 0);     chk("dn1_15", 15, 1, 0);
    tick(1, 2'b10, 1, 4'd0, 0, 0);  chk("load0", 0, 0, 0);
    tick(1, 2'b10, 1, 4'd15, 0, 0); chk("load15", 15, 0, 0);

    // up 2 skipping zero flags nothing
    tick(1, 2'b01, 1, 4'd13, 0, 0); chk("load13", 13, 0, 0);
    tick(1, 2'b01, 0, 0, 0, 0);     chk("up2_15", 15, 1, 0);
    tick(1, 2'b01, 0, 0, 0, 0);     chk("up2_skip0", 1, 0, 0);

    // reset on the edge that would produce 15
    tick(1, 2'b00, 1, 4'd14, 0, 0); chk("load14b", 14, 0, 0);
    tick(0, 2'b00, 0, 0, 0, 0);     chk("reset_mid", 0, 0, 0);
    tick(1, 2'b00, 0, 0, 0, 0);     chk("resume", 1, 0, 0);

    // reset on the edge that would wrap to 0
    tick(1, 2'b00, 1, 4'd15, 0, 0); chk("load15b", 15, 0, 0);
    tick(0, 2'b00, 0, 0, 0, 0);     chk("reset_nolose", 0, 0, 0);
    tick(1, 2'b01, 0, 0, 0, 0);     chk("resume2", 2, 0, 0);

`ifdef HOLD_PORT_EN
    tick(1, 2'b00, 1, 4'd6, 0, 0);  chk("load6", 6, 0, 0);
    tick(1, 2'b00, 1, 4'd9, 0, 1);  chk("hold_init", 6, 0, 0);
    tick(1, 2'b00, 0, 0, 0, 1);     chk("hold", 6, 0, 0);
    tick(1, 2'b00, 0, 0, 0, 0);     chk("after_hold", 7, 0, 0);
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
